// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data-memory controller.
package dmem_pkg;

    localparam int BE_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_align.sv
// Little-endian sub-word steering: store byte enables/lane data and load extraction.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic            unsigned_i,
    input  logic [31:0]     wdata_i,
    input  logic [31:0]     raw_i,
    output logic [BE_W-1:0] be_o,
    output logic [31:0]     wdata_o,
    output logic [31:0]     rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

    // Reserved size 2'b11 falls into the word branch.
    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = raw_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller with wait states and stall handshake.
// Define DMEM_MISALIGN_EXC_EN to raise AdEL/AdES on misaligned half/word accesses.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              exc_o,
    output logic              exc_store_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LA_W  = IDX_W + 2;
    localparam logic [2:0] LAT_M1 = 3'((LATENCY > 0) ? LATENCY - 1 : 0);

    // Handshake: req_i is held stable while stall_o=1; done_o marks the
    // first unstalled cycle, and rdata_o is valid in that cycle.
    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [LA_W-1:0]   addr_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              idle_d;
    logic              cur_we_d;
    logic [1:0]        cur_size_d;
    logic              cur_uns_d;
    logic [LA_W-1:0]   cur_addr_d;
    logic [31:0]       cur_wdata_d;
    logic [IDX_W-1:0]  idx_d;
    logic              mis_d;
    logic              last_d;
    logic [BE_W-1:0]   be_d;
    logic [31:0]       wsteer_d;
    logic [31:0]       load_d;
    logic              unused_addr;

    assign unused_addr = ^addr_i[ADDR_W-1:LA_W];

    // In IDLE the live inputs drive the datapath so LATENCY=0 completes in one edge.
    assign idle_d      = (state_q == IDLE);
    assign cur_we_d    = idle_d ? we_i              : we_q;
    assign cur_size_d  = idle_d ? size_i            : size_q;
    assign cur_uns_d   = idle_d ? unsigned_i        : uns_q;
    assign cur_addr_d  = idle_d ? addr_i[LA_W-1:0]  : addr_q;
    assign cur_wdata_d = idle_d ? wdata_i           : wdata_q;
    assign idx_d       = cur_addr_d[LA_W-1:2];

`ifdef DMEM_MISALIGN_EXC_EN
    assign mis_d = ((size_i == SZ_HALF) && addr_i[0]) ||
                   (size_i[1] && (addr_i[1:0] != 2'b00));
`else
    assign mis_d = 1'b0;
`endif

    assign last_d = (idle_d && req_i && !mis_d && (LATENCY == 0)) ||
                    ((state_q == BUSY) && req_i && (cnt_q == 3'd0));

    assign stall_o = req_i & (state_q != RESP);

    dmem_align u_align (
        .size_i     (cur_size_d),
        .addr_lo_i  (cur_addr_d[1:0]),
        .unsigned_i (cur_uns_d),
        .wdata_i    (cur_wdata_d),
        .raw_i      (mem_q[idx_d]),
        .be_o       (be_d),
        .wdata_o    (wsteer_d),
        .rdata_o    (load_d)
    );

    // Array contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (last_d && cur_we_d) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_d[b]) mem_q[idx_d][8*b +: 8] <= wsteer_d[8*b +: 8];
            end
        end
    end

`ifdef DMEM_MISALIGN_EXC_EN
    logic exc_q;
    logic exc_store_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
`ifdef DMEM_MISALIGN_EXC_EN
            exc_q       <= 1'b0;
            exc_store_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef DMEM_MISALIGN_EXC_EN
            exc_q       <= 1'b0;
            exc_store_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        size_q  <= size_i;
                        uns_q   <= unsigned_i;
                        addr_q  <= addr_i[LA_W-1:0];
                        wdata_q <= wdata_i;
                        if (mis_d) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            rdata_q <= '0;
`ifdef DMEM_MISALIGN_EXC_EN
                            exc_q       <= 1'b1;
                            exc_store_q <= we_i;
`endif
                        end else if (LATENCY == 0) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            if (!we_i) rdata_q <= load_d;
                        end else begin
                            cnt_q   <= LAT_M1;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!req_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 3'd0) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        if (!we_q) rdata_q <= load_d;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o  = done_q;
    assign rdata_o = rdata_q;
`ifdef DMEM_MISALIGN_EXC_EN
    assign exc_o       = exc_q;
    assign exc_store_o = exc_store_q;
`else
    assign exc_o       = 1'b0;
    assign exc_store_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: LATENCY=2 instance for data paths, LATENCY=3 for abort cases.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [1:0]  size  [2];
    logic        uns   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        stall [2];
    logic        done  [2];
    logic [31:0] rdata [2];
    logic        exc   [2];
    logic        excs  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(32), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
        .unsigned_i(uns[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .stall_o(stall[0]),
        .done_o(done[0]), .rdata_o(rdata[0]), .exc_o(exc[0]), .exc_store_o(excs[0])
    );

    dmem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(32), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
        .unsigned_i(uns[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .stall_o(stall[1]),
        .done_o(done[1]), .rdata_o(rdata[1]), .exc_o(exc[1]), .exc_store_o(excs[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Runs one access to completion; checks stall length and a single done pulse.
    task automatic access(input int u, input logic w, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_stalls,
                          output logic [31:0] rd, output logic ex, output logic exs);
        int stalls = 0;
        int dones  = 0;
        rd = 'x; ex = 'x; exs = 'x;
        @(negedge clk);
        req[u] = 1'b1; we[u] = w; size[u] = sz; uns[u] = un; addr[u] = a; wdata[u] = wd;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (stall[u]) stalls++;
            if (done[u]) begin
                dones++;
                rd = rdata[u]; ex = exc[u]; exs = excs[u];
                break;
            end
            @(negedge clk);
        end
        req[u] = 1'b0; we[u] = 1'b0;
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("done_seen", 32'(dones), 32'd1);
        @(negedge clk);
        #1 check("done_cleared", 32'(done[u]), 32'd0);
    endtask

    task automatic do_store(input int u, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        logic ex, exs;
        access(u, 1'b1, sz, 1'b0, a, wd, (u == 0) ? 3 : 4, rd, ex, exs);
        check("store_exc", 32'(ex), 32'd0);
    endtask

    task automatic do_load(input string tag, input int u, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] exp_v);
        logic [31:0] rd;
        logic ex, exs;
        access(u, 1'b0, sz, un, a, 32'h0, (u == 0) ? 3 : 4, rd, ex, exs);
        check(tag, rd, exp_v);
        check("load_exc", 32'(ex), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic ex, exs;
        int dcnt;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req[u] = 1'b0; we[u] = 1'b0; size[u] = SZ_WORD;
            uns[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
        end
        #12;
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_exc", 32'(exc[0]), 32'd0);
        check("rst_exc_store", 32'(excs[0]), 32'd0);
        check("rst_stall", 32'(stall[0]), 32'd0);
        check("rst_state", 32'(u_l2.state_q), 32'(IDLE));
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        do_store(0, SZ_WORD, 32'h100, 32'h12345678);
        do_load("lw_100", 0, SZ_WORD, 1'b0, 32'h100, 32'h12345678);

        do_store(0, SZ_WORD, 32'h100, 32'h0);
        do_store(0, SZ_BYTE, 32'h101, 32'h000000AB);
        do_load("lw_after_sb", 0, SZ_WORD, 1'b0, 32'h100, 32'h0000AB00);
        do_load("lb_101", 0, SZ_BYTE, 1'b0, 32'h101, 32'hFFFFFFAB);
        do_load("lbu_101", 0, SZ_BYTE, 1'b1, 32'h101, 32'h000000AB);

        do_store(0, SZ_HALF, 32'h102, 32'h00008001);
        do_load("lw_after_sh", 0, SZ_WORD, 1'b0, 32'h100, 32'h8001AB00);
        do_load("lh_102", 0, SZ_HALF, 1'b0, 32'h102, 32'hFFFF8001);
        do_load("lhu_102", 0, SZ_HALF, 1'b1, 32'h102, 32'h00008001);
        do_load("lh_100", 0, SZ_HALF, 1'b0, 32'h100, 32'hFFFFAB00);

        do_store(0, SZ_BYTE, 32'h103, 32'h0000007F);
        do_load("lb_103", 0, SZ_BYTE, 1'b0, 32'h103, 32'h0000007F);
        do_load("lw_after_sb3", 0, SZ_WORD, 1'b0, 32'h100, 32'h7F01AB00);

`ifdef DMEM_MISALIGN_EXC_EN
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, 1, rd, ex, exs);
        check("mis_lw_rdata", rd, 32'h0);
        check("mis_lw_exc", 32'(ex), 32'd1);
        check("mis_lw_exc_store", 32'(exs), 32'd0);
        access(0, 1'b1, SZ_HALF, 1'b0, 32'h101, 32'h0000FFFF, 1, rd, ex, exs);
        check("mis_sh_exc", 32'(ex), 32'd1);
        check("mis_sh_exc_store", 32'(exs), 32'd1);
        do_load("mis_sh_no_write", 0, SZ_WORD, 1'b0, 32'h100, 32'h7F01AB00);
`else
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, 3, rd, ex, exs);
        check("mis_lw_rdata", rd, 32'h7F01AB00);
        check("mis_lw_exc", 32'(ex), 32'd0);
        access(0, 1'b0, SZ_HALF, 1'b0, 32'h101, 32'h0, 3, rd, ex, exs);
        check("mis_lh_rdata", rd, 32'hFFFFAB00);
        check("mis_lh_exc", 32'(ex), 32'd0);
`endif

        do_store(0, SZ_WORD, 32'h1000, 32'hDEADBEEF);
        do_load("lw_wrap", 0, SZ_WORD, 1'b0, 32'h0, 32'hDEADBEEF);

        do_store(1, SZ_WORD, 32'h200, 32'h11111111);
        do_load("l3_lw_200", 1, SZ_WORD, 1'b0, 32'h200, 32'h11111111);

        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_WORD; addr[1] = 32'h200; wdata[1] = 32'hBADBAD00;
        @(negedge clk);
        #1 check("l3_busy_before_rst", 32'(u_l3.state_q), 32'(BUSY));
        req[1] = 1'b0; we[1] = 1'b0;
        rst[1] = 1'b1;
        #2;
        check("l3_rst_state", 32'(u_l3.state_q), 32'(IDLE));
        check("l3_rst_done", 32'(done[1]), 32'd0);
        rst[1] = 1'b0;
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            #1 if (done[1]) dcnt++;
        end
        check("l3_rst_no_done", 32'(dcnt), 32'd0);
        do_load("l3_rst_no_write", 1, SZ_WORD, 1'b0, 32'h200, 32'h11111111);

        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_WORD; addr[1] = 32'h200; wdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        #1 check("l3_busy_before_flush", 32'(u_l3.state_q), 32'(BUSY));
        @(negedge clk);
        req[1] = 1'b0; we[1] = 1'b0;
        @(negedge clk);
        #1 check("l3_flush_state", 32'(u_l3.state_q), 32'(IDLE));
        dcnt = 0;
        repeat (6) begin
            #1 if (done[1]) dcnt++;
            @(negedge clk);
        end
        check("l3_flush_no_done", 32'(dcnt), 32'd0);
        do_load("l3_flush_no_write", 1, SZ_WORD, 1'b0, 32'h200, 32'h11111111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory controller for the MIPS pipeline's MEM stage.
- Replaces the single-cycle, word-only data memory with an internal word array with sub-word support:
  - byte-enable generation for stores (SB/SH/SW);
  - load extraction with sign/zero extension (LB/LBU/LH/LHU/LW);
  - a configurable wait-state latency, exposed to the pipeline through a stall handshake.
- Sits between the core's MEM-stage signals and memory storage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- ADDR_W, 32, width of the byte address input.
- LATENCY, 1, wait states per access, 0..7.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  access request from the MEM stage; held stable while stall_o=1.
- we_i  in  1  1=store, 0=load.
- size_i  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word).
- unsigned_i  in  1  loads only; 1=zero-extend, 0=sign-extend.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, right-aligned.
- stall_o  out  1  pipeline hold.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load data; valid while done_o=1.
- exc_o  out  1  misaligned-access exception; active only with the optional feature.
- exc_store_o  out  1  qualifies exc_o: 1=store (AdES), 0=load (AdEL).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, wait counter=0.
  - done_o=0, rdata_o=0, exc_o=0, exc_store_o=0.
  - Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_i=1 → latch we, size, unsigned, address and wdata.
  - LATENCY=0 → next state RESP; otherwise counter=LATENCY-1, next state BUSY.
- BUSY:
  - Counter decrements each cycle; at 0 → RESP.
  - req_i=0 during BUSY (flush) → IDLE with no write performed and no done_o.
- RESP:
  - Stores commit at the edge entering RESP; loads register rdata_o on that edge.
  - done_o=1 for exactly one cycle.
  - Always returns to IDLE next cycle; req_i is not sampled in RESP.
- stall_o = req_i & (state != RESP); combinational.
  - An accepted access stalls LATENCY+1 cycles; done_o coincides with the first unstalled cycle.
- Back-to-back: a new request presented in the cycle after RESP is accepted in IDLE. Minimum issue interval is LATENCY+2 cycles.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (address wraps modulo DEPTH_WORDS*4).
- Little-endian store steering:
  - byte: be=0001<<addr[1:0], data byte replicated to all lanes.
  - half: be = addr[1] ? 1100 : 0011, half replicated.
  - word: be=1111.
- Load extraction:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - Sign-extended unless unsigned_i=1; word loads pass through.
- Reset mid-BUSY: access aborted, no write, state IDLE.

Optional Feature:
- Macro: DMEM_MISALIGN_EXC_EN.
- Misaligned access = half with addr[0]=1, or word with addr[1:0]!=0.
- With the macro:
  - A misaligned access is accepted in IDLE and goes directly to RESP, skipping BUSY.
  - No array read or write occurs.
  - In RESP: exc_o=1 and exc_store_o=we for one cycle, done_o=1, rdata_o=0.
- Without the macro:
  - exc_o and exc_store_o are tied 0.
  - Low address bits are masked: half ignores addr[0]; word ignores addr[1:0].
  - The access proceeds normally.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum (IDLE, BUSY, RESP);
  - constant BE_W=4.
- One combinational sub-module, dmem_align:
  - from size/addr/wdata → byte enables and steered write data;
  - from raw word/size/addr/unsigned → extended load data.
- FSM, counter and array stay in dmem_ctrl.

Test Plan:
- LATENCY=2; SW 0x12345678 @0x100, then LW @0x100 → stall_o high 3 cycles per access; done_o pulses once; rdata_o=0x12345678.
- SB 0x000000AB @0x101 over word 0 → word=0x0000AB00; LB @0x101 → 0xFFFFFFAB; LBU @0x101 → 0x000000AB.
- SH 0x8001 @0x102 → upper half written, lower half unchanged; LH @0x102 → 0xFFFF8001; LHU @0x102 → 0x00008001.
- DEPTH_WORDS=1024: SW 0xDEADBEEF @0x1000, then LW @0x0 → 0xDEADBEEF (wrap).
- LW @0x102 misaligned:
  - with DMEM_MISALIGN_EXC_EN → exc_o=1, exc_store_o=0, rdata_o=0, no BUSY cycles;
  - without the macro → reads word @0x100.
- LATENCY=3; SW accepted, rst pulsed during BUSY (also repeated with req_i dropped mid-BUSY) → state IDLE, done_o never asserts, target word unchanged.
